// File: rtl/fetch_queue_mt_pkg.sv
// Shared types for the multithreaded fetch queue: thread mode, fetch exception
// record and the default queue entry layout.
package fetch_queue_mt_pkg;
  localparam int THR_PER_CORE = 4;
  localparam int FQ_DEPTH     = 4;
  localparam int INSTR_WIDTH  = 32;
  localparam int PC_WIDTH     = 32;

  typedef enum logic [1:0] {
    Single_Threaded = 2'd0,
    Coarse_Grained  = 2'd1,
    Fine_Grained    = 2'd2
  } multithreading_mode_t;

  typedef struct packed {
    logic                itlb_miss;
    logic                bus_error;
    logic [PC_WIDTH-1:0] addr;
  } fetch_xcpt_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    fetch_xcpt_t            xcpt;
  } fetch_queue_entry_t;

  // Only thread 0 may enqueue or be selected in single-threaded mode.
  function automatic logic thread_enabled(input multithreading_mode_t mode,
                                          input int unsigned tid);
    return (tid == 0) || (mode != Single_Threaded);
  endfunction
endpackage

// File: rtl/fetch_queue_mt_thread_queue.sv
// Single-thread FIFO: push at tail, pop at head, flush empties it at once.
// Caller guarantees push only when not full and pop only when not empty.
module fetch_queue_mt_thread_queue #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 98
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [ENTRY_W-1:0]           entry,
  output logic [ENTRY_W-1:0]           head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no control meaning, so it is never cleared.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= entry;
  end

  assign head_entry = mem[head];
  assign full       = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/fetch_queue_mt.sv
// Per-thread fetch queues feeding a registered decode interface; one ready
// thread is chosen round-robin each cycle, with per-thread flush and stall.
module fetch_queue_mt
  import fetch_queue_mt_pkg::*;
#(
  parameter int NUM_THREADS = THR_PER_CORE,
  parameter int DEPTH       = FQ_DEPTH,
  parameter int INSTR_W     = INSTR_WIDTH,
  parameter int PC_W        = PC_WIDTH,
  localparam int TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  multithreading_mode_t              mt_mode,
  input  logic                              enq_valid,
  input  logic [TID_W-1:0]                  enq_thread_id,
  input  logic [PC_W-1:0]                   enq_pc,
  input  logic [INSTR_W-1:0]                enq_instr,
  input  fetch_xcpt_t                       enq_xcpt,
  output logic [NUM_THREADS-1:0]            enq_ready,
  input  logic [NUM_THREADS-1:0]            flush,
  input  logic [NUM_THREADS-1:0]            stall_decode,
  output logic                              deq_valid,
  output logic [TID_W-1:0]                  deq_thread_id,
  output logic [PC_W-1:0]                   deq_pc,
  output logic [INSTR_W-1:0]                deq_instr,
  output fetch_xcpt_t                       deq_xcpt,
  output logic [NUM_THREADS-1:0][CNT_W-1:0] occupancy,
  output logic                              overflow_err
);
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    fetch_xcpt_t        xcpt;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t                           enq_entry;
  entry_t                           head_entry [NUM_THREADS];
  logic [NUM_THREADS-1:0][CNT_W-1:0] count;
  logic [NUM_THREADS-1:0]           push;
  logic [NUM_THREADS-1:0]           pop;
  logic [NUM_THREADS-1:0]           full;
  logic [NUM_THREADS-1:0]           eligible;
  logic [TID_W-1:0]                 last_grant;
  logic [TID_W-1:0]                 grant;
  logic [TID_W-1:0]                 idx;
  logic                             grant_valid;
  logic                             hold;
  logic                             reload;
  logic                             overflow_hit;
  entry_t                           sel_entry_p0;

  assign enq_entry = {enq_pc, enq_instr, enq_xcpt};

  // Stage p0: per-thread queues and enqueue/pop qualification.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    assign push[t] = enq_valid && (enq_thread_id == TID_W'(t)) && !full[t]
                     && !flush[t] && thread_enabled(mt_mode, t);
    assign eligible[t] = (count[t] != '0) && !flush[t] && !stall_decode[t]
                         && thread_enabled(mt_mode, t);
    assign pop[t] = reload && grant_valid && (grant == TID_W'(t));

    fetch_queue_mt_thread_queue #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
    ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push[t]),
      .pop        (pop[t]),
      .flush      (flush[t]),
      .entry      (enq_entry),
      .head_entry (head_entry[t]),
      .count      (count[t]),
      .full       (full[t])
    );
  end

  assign enq_ready    = ~full;
  assign occupancy    = count;
  assign overflow_hit = enq_valid && full[enq_thread_id] && !flush[enq_thread_id];
  assign hold         = deq_valid && stall_decode[deq_thread_id];
  assign reload       = !hold;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = TID_W'((int'(last_grant) + i) % NUM_THREADS);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  assign sel_entry_p0 = head_entry[grant];

  // Stage p1: registered decode interface and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      deq_valid     <= 1'b0;
      deq_thread_id <= '0;
      deq_pc        <= '0;
      deq_instr     <= '0;
      deq_xcpt      <= '0;
      last_grant    <= '0;
      overflow_err  <= 1'b0;
    end else begin
      if (overflow_hit) overflow_err <= 1'b1;
      if (hold) begin
        if (flush[deq_thread_id]) deq_valid <= 1'b0;
      end else if (grant_valid) begin
        deq_valid     <= 1'b1;
        deq_thread_id <= grant;
        deq_pc        <= sel_entry_p0.pc;
        deq_instr     <= sel_entry_p0.instr;
        deq_xcpt      <= sel_entry_p0.xcpt;
        last_grant    <= grant;
      end else begin
        deq_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_mt.sv
// Directed bench for fetch_queue_mt: table of per-cycle vectors plus
// hand-written sequences for stall, flush, overflow, mode and reset cases.
module tb_fetch_queue_mt;
  import fetch_queue_mt_pkg::*;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int CW = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  multithreading_mode_t     mt_mode;
  logic                     enq_valid;
  logic [TW-1:0]            enq_thread_id;
  logic [31:0]              enq_pc;
  logic [31:0]              enq_instr;
  fetch_xcpt_t              enq_xcpt;
  logic [NT-1:0]            enq_ready;
  logic [NT-1:0]            flush;
  logic [NT-1:0]            stall_decode;
  logic                     deq_valid;
  logic [TW-1:0]            deq_thread_id;
  logic [31:0]              deq_pc;
  logic [31:0]              deq_instr;
  fetch_xcpt_t              deq_xcpt;
  logic [NT-1:0][CW-1:0]    occupancy;
  logic                     overflow_err;

  int errors = 0;
  int checks = 0;

  fetch_queue_mt dut (
    .clock         (clock),
    .reset         (reset),
    .mt_mode       (mt_mode),
    .enq_valid     (enq_valid),
    .enq_thread_id (enq_thread_id),
    .enq_pc        (enq_pc),
    .enq_instr     (enq_instr),
    .enq_xcpt      (enq_xcpt),
    .enq_ready     (enq_ready),
    .flush         (flush),
    .stall_decode  (stall_decode),
    .deq_valid     (deq_valid),
    .deq_thread_id (deq_thread_id),
    .deq_pc        (deq_pc),
    .deq_instr     (deq_instr),
    .deq_xcpt      (deq_xcpt),
    .occupancy     (occupancy),
    .overflow_err  (overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        enq;
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [3:0]  stall;
    logic        exp_valid;
    logic [1:0]  exp_tid;
    logic [31:0] exp_pc;
    logic [11:0] exp_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hDEAD, pc[15:0] ^ 16'h1001};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    enq_valid     = 1'b0;
    enq_thread_id = '0;
    enq_pc        = '0;
    enq_instr     = '0;
    enq_xcpt      = '0;
    flush         = '0;
    stall_decode  = '0;
  endtask

  task automatic set_enq(input logic [1:0] t, input logic [31:0] pc);
    enq_valid     = 1'b1;
    enq_thread_id = t;
    enq_pc        = pc;
    enq_instr     = instr_of(pc);
    enq_xcpt      = '0;
  endtask

  task automatic chk_deq(input string tag, input logic v, input logic [1:0] t,
                         input logic [31:0] pc);
    chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(v));
    if (v) begin
      chk({tag, ".deq_thread_id"}, 64'(deq_thread_id), 64'(t));
      chk({tag, ".deq_pc"}, 64'(deq_pc), 64'(pc));
      chk({tag, ".deq_instr"}, 64'(deq_instr), 64'(instr_of(pc)));
    end
  endtask

  task automatic add(input logic e, input logic [1:0] t, input logic [31:0] pc,
                     input logic [3:0] st, input logic ev, input logic [1:0] et,
                     input logic [31:0] ep, input logic [11:0] eo);
    vec_t v;
    v.enq = e; v.tid = t; v.pc = pc; v.stall = st;
    v.exp_valid = ev; v.exp_tid = et; v.exp_pc = ep; v.exp_occ = eo;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(0));
    chk({tag, ".deq_thread_id"}, 64'(deq_thread_id), 64'(0));
    chk({tag, ".deq_pc"}, 64'(deq_pc), 64'(0));
    chk({tag, ".deq_instr"}, 64'(deq_instr), 64'(0));
    chk({tag, ".deq_xcpt"}, 64'(deq_xcpt), 64'(0));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(0));
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(4'hF));
    chk({tag, ".overflow_err"}, 64'(overflow_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  initial begin
    fetch_xcpt_t xe;

    // T1 basic latency, then T3 round-robin after filling every thread with 2 entries.
    add(1, 0, 32'h1000, 4'h0, 0, 0, 32'h0,    12'h001);
    add(0, 0, 32'h0,    4'h0, 1, 0, 32'h1000, 12'h000);
    add(0, 0, 32'h0,    4'h0, 0, 0, 32'h1000, 12'h000);
    add(1, 0, 32'h2000, 4'hF, 0, 0, 32'h1000, 12'h001);
    add(1, 0, 32'h2004, 4'hF, 0, 0, 32'h1000, 12'h002);
    add(1, 1, 32'h2100, 4'hF, 0, 0, 32'h1000, 12'h00A);
    add(1, 1, 32'h2104, 4'hF, 0, 0, 32'h1000, 12'h012);
    add(1, 2, 32'h2200, 4'hF, 0, 0, 32'h1000, 12'h052);
    add(1, 2, 32'h2204, 4'hF, 0, 0, 32'h1000, 12'h092);
    add(1, 3, 32'h2300, 4'hF, 0, 0, 32'h1000, 12'h292);
    add(1, 3, 32'h2304, 4'hF, 0, 0, 32'h1000, 12'h492);
    add(0, 0, 32'h0,    4'h0, 1, 1, 32'h2100, 12'h48A);
    add(0, 0, 32'h0,    4'h0, 1, 2, 32'h2200, 12'h44A);
    add(0, 0, 32'h0,    4'h0, 1, 3, 32'h2300, 12'h24A);
    add(0, 0, 32'h0,    4'h0, 1, 0, 32'h2000, 12'h249);
    add(0, 0, 32'h0,    4'h0, 1, 1, 32'h2104, 12'h241);
    add(0, 0, 32'h0,    4'h0, 1, 2, 32'h2204, 12'h201);
    add(0, 0, 32'h0,    4'h0, 1, 3, 32'h2304, 12'h001);
    add(0, 0, 32'h0,    4'h0, 1, 0, 32'h2004, 12'h000);
    add(0, 0, 32'h0,    4'h0, 0, 0, 32'h2004, 12'h000);

    mt_mode = Fine_Grained;
    drive_idle();
    reset = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive_idle();
      if (vecs[i].enq) set_enq(vecs[i].tid, vecs[i].pc);
      stall_decode = vecs[i].stall;
      step();
      chk($sformatf("vec%0d.deq_valid", i), 64'(deq_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.deq_thread_id", i), 64'(deq_thread_id), 64'(vecs[i].exp_tid));
      chk($sformatf("vec%0d.deq_pc", i), 64'(deq_pc), 64'(vecs[i].exp_pc));
      chk($sformatf("vec%0d.deq_instr", i), 64'(deq_instr),
          64'((vecs[i].exp_pc == 32'h0) ? 32'h0 : instr_of(vecs[i].exp_pc)));
      chk($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      chk($sformatf("vec%0d.enq_ready", i), 64'(enq_ready), 64'(4'hF));
    end

    // T2: fill t1 under stall, overflow on the fifth, then drain in order.
    drive_idle();
    stall_decode = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_enq(2'd1, 32'h3000 + 32'(4 * k));
      if (k == 0) begin
        enq_xcpt.bus_error = 1'b1;
        enq_xcpt.addr      = 32'h3000;
      end
      step();
    end
    chk("t2.full.enq_ready", 64'(enq_ready), 64'(4'b1101));
    chk("t2.full.occ1", 64'(occupancy[1]), 64'(4));
    chk("t2.full.overflow", 64'(overflow_err), 64'(0));
    chk("t2.full.deq_valid", 64'(deq_valid), 64'(0));
    set_enq(2'd1, 32'h3010);
    step();
    chk("t2.ovf.occ1", 64'(occupancy[1]), 64'(4));
    chk("t2.ovf.overflow", 64'(overflow_err), 64'(1));
    chk("t2.ovf.enq_ready", 64'(enq_ready), 64'(4'b1101));
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      step();
      chk_deq($sformatf("t2.drain%0d", k), 1'b1, 2'd1, 32'h3000 + 32'(4 * k));
      if (k == 0) begin
        xe = '0;
        xe.bus_error = 1'b1;
        xe.addr = 32'h3000;
        chk("t2.drain0.deq_xcpt", 64'(deq_xcpt), 64'(xe));
        chk("t2.drain0.enq_ready", 64'(enq_ready), 64'(4'hF));
      end
    end
    step();
    chk_deq("t2.empty", 1'b0, 2'd0, 32'h0);
    chk("t2.empty.overflow", 64'(overflow_err), 64'(1));

    // T4: hold thread 2 under stall, then flush it while presented.
    drive_idle();
    set_enq(2'd2, 32'h4000);
    step();
    chk("t4.occ2.a", 64'(occupancy[2]), 64'(1));
    set_enq(2'd2, 32'h4004);
    step();
    chk_deq("t4.first", 1'b1, 2'd2, 32'h4000);
    chk("t4.occ2.b", 64'(occupancy[2]), 64'(1));
    set_enq(2'd2, 32'h4008);
    stall_decode = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_deq($sformatf("t4.hold%0d", k), 1'b1, 2'd2, 32'h4000);
      chk($sformatf("t4.hold%0d.occ2", k), 64'(occupancy[2]), 64'(2));
      enq_valid = 1'b0;
    end
    flush = 4'b0100;
    step();
    chk("t4.flush.deq_valid", 64'(deq_valid), 64'(0));
    chk("t4.flush.occ2", 64'(occupancy[2]), 64'(0));
    drive_idle();
    step();
    chk("t4.after.deq_valid", 64'(deq_valid), 64'(0));
    chk("t4.after.occupancy", 64'(occupancy), 64'(0));

    // T5: flush and enqueue on t1 together, first on a full queue, then empty.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5.reset.overflow", 64'(overflow_err), 64'(0));
    stall_decode = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_enq(2'd1, 32'h7000 + 32'(4 * k));
      step();
    end
    chk("t5.full.occ1", 64'(occupancy[1]), 64'(4));
    set_enq(2'd1, 32'h7010);
    flush = 4'b0010;
    step();
    chk("t5.flushfull.occ1", 64'(occupancy[1]), 64'(0));
    chk("t5.flushfull.overflow", 64'(overflow_err), 64'(0));
    chk("t5.flushfull.enq_ready", 64'(enq_ready), 64'(4'hF));
    drive_idle();
    set_enq(2'd1, 32'h6000);
    flush = 4'b0010;
    step();
    chk("t5.flushenq.occ1", 64'(occupancy[1]), 64'(0));
    chk("t5.flushenq.overflow", 64'(overflow_err), 64'(0));
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("t5.idle%0d.deq_valid", k), 64'(deq_valid), 64'(0));
    end

    // T6: single-threaded mode ignores thread 3; reset mid-stream.
    stall_decode = 4'b1000;
    set_enq(2'd3, 32'h5300);
    step();
    chk("t6.pre.occ3", 64'(occupancy[3]), 64'(1));
    mt_mode = Single_Threaded;
    stall_decode = '0;
    set_enq(2'd3, 32'h5304);
    step();
    chk("t6.drop.occ3", 64'(occupancy[3]), 64'(1));
    chk("t6.drop.deq_valid", 64'(deq_valid), 64'(0));
    set_enq(2'd0, 32'h5100);
    step();
    chk("t6.enq0.occ0", 64'(occupancy[0]), 64'(1));
    chk("t6.enq0.deq_valid", 64'(deq_valid), 64'(0));
    set_enq(2'd0, 32'h5104);
    step();
    chk_deq("t6.out0", 1'b1, 2'd0, 32'h5100);
    enq_valid = 1'b0;
    step();
    chk_deq("t6.out1", 1'b1, 2'd0, 32'h5104);
    chk("t6.out1.occ3", 64'(occupancy[3]), 64'(1));
    step();
    chk("t6.idle.deq_valid", 64'(deq_valid), 64'(0));
    set_enq(2'd0, 32'h5108);
    step();
    chk("t6.pre_rst.occ0", 64'(occupancy[0]), 64'(1));
    set_enq(2'd0, 32'h510C);
    reset = 1'b1;
    step();
    chk_reset_state("t6.reset");
    reset = 1'b0;
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
